// File: rtl/pbit_output_sampler.sv
// Output P-bit sampler: burn-in, then periodic sampling of the output P-bits into per-bit ones-counts.
// Optional majority-vote decode enabled by defining PBIT_SAMPLER_MAJORITY_EN.
module pbit_output_sampler_lane #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_smp,
    input  logic             i_bit,
`ifdef PBIT_SAMPLER_MAJORITY_EN
    input  logic             i_upd,
    input  logic [CNT_W-1:0] i_half,
    output logic             o_maj,
`endif
    output logic [CNT_W-1:0] o_cnt
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt;

    // A start clears in the same edge, so the next value is built from zero.
    assign w_nxt = (i_clr ? '0 : r_cnt) + {{(CNT_W-1){1'b0}}, i_smp & i_bit};
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_clr || i_smp)
            r_cnt <= w_nxt;
    end

`ifdef PBIT_SAMPLER_MAJORITY_EN
    logic r_maj;
    assign o_maj = r_maj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_maj <= 1'b0;
        else if (i_upd)
            r_maj <= (w_nxt > i_half);
        else if (i_clr)
            r_maj <= 1'b0;
    end
`endif
endmodule

module pbit_output_sampler #(
    parameter int N_PBITS = 53,
    parameter int N_OUT   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m         [0:N_PBITS-1],
    input  logic             start,
    input  logic [15:0]      burn_in,
    input  logic [7:0]       interval,
    input  logic [CNT_W-1:0] n_samples,
    output logic             busy,
    output logic [CNT_W-1:0] cnt       [0:N_OUT-1],
    output logic             valid,
    input  logic             ready,
    output logic             majority  [0:N_OUT-1]
);
    typedef enum logic [1:0] {IDLE, BURN, SAMPLE, DONE} state_t;

    state_t           r_state;
    logic [15:0]      r_burn;
    logic [7:0]       r_ival;
    logic [7:0]       r_icnt;
    logic [CNT_W-1:0] r_nsmp;
    logic [CNT_W-1:0] r_scnt;
    logic             r_busy;
    logic             r_valid;

    logic             w_clr;
    logic             w_smp;
    logic             w_last;
    logic [CNT_W-1:0] w_scnt_inc;
    logic             w_unused;

    assign w_clr      = (r_state == IDLE) && start;
    assign w_smp      = (r_state == SAMPLE) && (r_icnt == 8'd0);
    assign w_scnt_inc = r_scnt + 1'b1;
    assign w_last     = w_smp && (w_scnt_inc == r_nsmp);
    assign busy       = r_busy;
    assign valid      = r_valid;

    // Only the top N_OUT P-bits are observed; the rest are intentionally ignored.
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < N_PBITS - N_OUT; k++)
            w_unused = w_unused ^ m[k];
    end

`ifdef PBIT_SAMPLER_MAJORITY_EN
    logic             w_to_done;
    logic [CNT_W-1:0] w_half;
    assign w_to_done = (w_clr && burn_in == 16'd0 && n_samples == '0) ||
                       (r_state == BURN && r_burn == 16'd1 && r_nsmp == '0) ||
                       w_last;
    assign w_half    = (r_state == IDLE) ? (n_samples >> 1) : (r_nsmp >> 1);
`endif

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        pbit_output_sampler_lane #(.CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_clr),
            .i_smp (w_smp),
            .i_bit (m[N_PBITS-N_OUT+i]),
`ifdef PBIT_SAMPLER_MAJORITY_EN
            .i_upd (w_to_done),
            .i_half(w_half),
            .o_maj (majority[i]),
`endif
            .o_cnt (cnt[i])
        );
`ifndef PBIT_SAMPLER_MAJORITY_EN
        assign majority[i] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_burn  <= '0;
            r_ival  <= '0;
            r_icnt  <= '0;
            r_nsmp  <= '0;
            r_scnt  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_burn <= burn_in;
                    r_ival <= interval;
                    r_nsmp <= n_samples;
                    r_scnt <= '0;
                    r_icnt <= '0;
                    r_busy <= 1'b1;
                    if (burn_in != 16'd0)
                        r_state <= BURN;
                    else if (n_samples != '0)
                        r_state <= SAMPLE;
                    else begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end
                end
                BURN: begin
                    r_burn <= r_burn - 16'd1;
                    if (r_burn == 16'd1) begin
                        if (r_nsmp != '0)
                            r_state <= SAMPLE;
                        else begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                        end
                    end
                end
                SAMPLE: begin
                    if (w_smp) begin
                        r_scnt <= w_scnt_inc;
                        r_icnt <= r_ival;
                        if (w_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b1;
                        end
                    end else
                        r_icnt <= r_icnt - 8'd1;
                end
                DONE: if (ready) begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pbit_output_sampler.sv
// Directed self-checking bench for pbit_output_sampler.
module tb_pbit_output_sampler;
    localparam int NP = 53;
    localparam int NO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m [0:NP-1];
    logic          start = 1'b0;
    logic [15:0]   burn_in = '0;
    logic [7:0]    interval = '0;
    logic [CW-1:0] n_samples = '0;
    logic          busy;
    logic [CW-1:0] cnt [0:NO-1];
    logic          valid;
    logic          ready = 1'b0;
    logic          majority [0:NO-1];

    int chk = 0;
    int fails = 0;
    int exp_cnt [0:NO-1];

    pbit_output_sampler #(.N_PBITS(NP), .N_OUT(NO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .m(m), .start(start), .burn_in(burn_in),
        .interval(interval), .n_samples(n_samples), .busy(busy), .cnt(cnt),
        .valid(valid), .ready(ready), .majority(majority)
    );

    always #5 clk = ~clk;

    // Starts a run at a negedge (cycle 0) and drives m until valid is seen.
    // mode 0: fixed pattern, 1: m[45] toggles starting at 1, 2: random bits.
    task automatic go(input int b, input int iv, input int s, input int mode,
                      input logic [7:0] pat, output int vcyc, output logic b1);
        int k;
        vcyc = -1;
        b1 = 1'b0;
        for (int j = 0; j < NO; j++) exp_cnt[j] = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1; burn_in = 16'(b); interval = 8'(iv); n_samples = CW'(s);
            end else begin
                if (c == 1) begin
                    start = 1'b0; b1 = busy;
                    burn_in = 16'hFFFF; interval = 8'hFF; n_samples = '1;
                end
                if (valid) begin vcyc = c; break; end
            end
            for (int j = 0; j < NP - NO; j++) m[j] = (mode == 2) ? 1'($urandom) : 1'b0;
            for (int j = 0; j < NO; j++) begin
                case (mode)
                    0: m[NP-NO+j] = pat[j];
                    1: m[NP-NO+j] = (j == 0) ? ((c % 2) == 0) : 1'b0;
                    default: m[NP-NO+j] = 1'($urandom);
                endcase
            end
            k = (c - b - 1) / (iv + 1);
            if (c >= b + 1 && ((c - b - 1) % (iv + 1)) == 0 && k < s)
                for (int j = 0; j < NO; j++) exp_cnt[j] += int'(m[NP-NO+j]);
        end
    endtask

    task automatic handshake();
        @(negedge clk); ready = 1'b1;
        @(negedge clk); ready = 1'b0;
    endtask

    task automatic test_reset();
        chk++; if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++; $display("FAIL reset_ctl busy=%b valid=%b want 0/0", busy, valid);
        end
        for (int j = 0; j < NO; j++) begin
            chk++; if (cnt[j] !== '0 || majority[j] !== 1'b0) begin
                fails++; $display("FAIL reset_cnt[%0d] cnt=%0d maj=%b want 0/0", j, cnt[j], majority[j]);
            end
        end
    endtask

    task automatic test_pattern();
        int v; logic b1;
        logic [7:0] pat;
        int want [0:NO-1];
        pat = 8'b1010_0101;
        want = '{10, 0, 10, 0, 0, 10, 0, 10};
        go(0, 0, 10, 0, pat, v, b1);
        chk++; if (b1 !== 1'b1) begin fails++; $display("FAIL pat_busy_c1 got=%b want=1", b1); end
        chk++; if (v != 11) begin fails++; $display("FAIL pat_valid_cycle got=%0d want=11", v); end
        for (int j = 0; j < NO; j++) begin
            chk++; if (cnt[j] !== CW'(want[j])) begin
                fails++; $display("FAIL pat_cnt[%0d] got=%0d want=%0d", j, cnt[j], want[j]);
            end
`ifdef PBIT_SAMPLER_MAJORITY_EN
            chk++; if (majority[j] !== pat[j]) begin
`else
            chk++; if (majority[j] !== 1'b0) begin
`endif
                fails++; $display("FAIL pat_maj[%0d] got=%b", j, majority[j]);
            end
        end
        handshake();
        chk++; if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++; $display("FAIL pat_after_hs busy=%b valid=%b want 0/0", busy, valid);
        end
    endtask

    task automatic test_interval();
        int v; logic b1;
        go(5, 2, 4, 1, 8'h00, v, b1);
        chk++; if (v != 16) begin fails++; $display("FAIL ivl_valid_cycle got=%0d want=16", v); end
        chk++; if (cnt[0] !== 16'd2) begin fails++; $display("FAIL ivl_cnt0 got=%0d want=2", cnt[0]); end
        chk++; if (cnt[1] !== 16'd0) begin fails++; $display("FAIL ivl_cnt1 got=%0d want=0", cnt[1]); end
        chk++; if (majority[0] !== 1'b0) begin fails++; $display("FAIL ivl_maj0 got=%b want=0", majority[0]); end
        handshake();
    endtask

    task automatic test_zero_samples();
        int v; logic b1;
        go(3, 0, 0, 0, 8'hFF, v, b1);
        chk++; if (v != 4) begin fails++; $display("FAIL zs_valid_cycle got=%0d want=4", v); end
        for (int j = 0; j < NO; j++) begin
            chk++; if (cnt[j] !== '0) begin fails++; $display("FAIL zs_cnt[%0d] got=%0d want=0", j, cnt[j]); end
        end
        handshake();
    endtask

    task automatic test_hold();
        int v; logic b1;
        go(0, 0, 2, 0, 8'hFF, v, b1);
        chk++; if (v != 3) begin fails++; $display("FAIL hold_valid_cycle got=%0d want=3", v); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = (k == 5); burn_in = 16'd0; n_samples = CW'(1);
            chk++; if (valid !== 1'b1 || cnt[3] !== 16'd2 || busy !== 1'b1) begin
                fails++; $display("FAIL hold_k%0d valid=%b busy=%b cnt3=%0d want 1/1/2", k, valid, busy, cnt[3]);
            end
        end
        @(negedge clk); start = 1'b1; ready = 1'b1;
        @(negedge clk); start = 1'b0; ready = 1'b0;
        chk++; if (busy !== 1'b0 || valid !== 1'b0) begin
            fails++; $display("FAIL hold_hs busy=%b valid=%b want 0/0", busy, valid);
        end
        @(negedge clk);
        chk++; if (busy !== 1'b0 || cnt[3] !== 16'd2) begin
            fails++; $display("FAIL hold_start_ign busy=%b cnt3=%0d want 0/2", busy, cnt[3]);
        end
    endtask

    task automatic test_reset_mid();
        int v; logic b1;
        for (int j = 0; j < NO; j++) m[NP-NO+j] = 1'b1;
        @(negedge clk); start = 1'b1; burn_in = 16'd0; interval = 8'd0; n_samples = CW'(8);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk++; if (cnt[0] !== 16'd3) begin fails++; $display("FAIL rmid_pre cnt0=%0d want=3", cnt[0]); end
        rst = 1'b1;
        #1;
        chk++; if (busy !== 1'b0 || valid !== 1'b0 || cnt[0] !== '0 || cnt[7] !== '0) begin
            fails++; $display("FAIL rmid_async busy=%b valid=%b cnt0=%0d want 0/0/0", busy, valid, cnt[0]);
        end
        @(negedge clk); rst = 1'b0;
        go(0, 0, 2, 0, 8'hFF, v, b1);
        chk++; if (v != 3 || cnt[0] !== 16'd2) begin
            fails++; $display("FAIL rmid_rerun vcyc=%0d cnt0=%0d want 3/2", v, cnt[0]);
        end
        handshake();
    endtask

    task automatic test_random();
        int v; logic b1;
        go(0, 0, 1000, 2, 8'h00, v, b1);
        chk++; if (v != 1001) begin fails++; $display("FAIL rnd_valid_cycle got=%0d want=1001", v); end
        for (int j = 0; j < NO; j++) begin
            chk++; if (cnt[j] !== CW'(exp_cnt[j])) begin
                fails++; $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", j, cnt[j], exp_cnt[j]);
            end
`ifdef PBIT_SAMPLER_MAJORITY_EN
            chk++; if (majority[j] !== (exp_cnt[j] > 500)) begin
`else
            chk++; if (majority[j] !== 1'b0) begin
`endif
                fails++; $display("FAIL rnd_maj[%0d] got=%b cnt=%0d", j, majority[j], exp_cnt[j]);
            end
        end
        handshake();
    endtask

    initial begin
        for (int j = 0; j < NP; j++) m[j] = 1'b0;
        #12;
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_pattern();
        test_interval();
        test_zero_samples();
        test_hold();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", chk - fails, chk);
        $finish;
    end
endmodule
